// File: rtl/game_state_controller.sv
// Per-frame collision, lives and respawn controller: scans enemy slots against
// the player and sword once per frame, then resolves kills, hits and game-over.
module game_state_controller #(
  parameter int unsigned NUM_ENEMIES   = 4,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_FRAMES = 30,
  parameter logic [7:0]  RESPAWN_POS   = 8'h13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_trigger,
  input  logic                     restart,
  input  logic [7:0]               player_pos,
  input  logic [7:0]               sword_pos,
  input  logic [3:0]               sword_visible,
  input  logic [8*NUM_ENEMIES-1:0] enemy_pos,
  input  logic [NUM_ENEMIES-1:0]   enemy_alive,
  output logic [NUM_ENEMIES-1:0]   enemy_kill,
  output logic                     player_hit,
  output logic                     respawn_req,
  output logic [7:0]               respawn_pos,
  output logic [2:0]               lives,
  output logic [7:0]               score,
  output logic                     invulnerable,
  output logic                     game_over,
  output logic                     busy,
  output logic                     frame_overrun
);

  localparam int unsigned IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int unsigned INV_W = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENEMIES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN      = 2'd1,
    RESOLVE   = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_ENEMIES-1:0] kill_acc_q, kill_acc_d;
  logic                   hit_q, hit_d;
  logic [2:0]             lives_q, lives_d;
  logic [7:0]             score_q, score_d;
  logic [INV_W-1:0]       inv_q, inv_d;
  logic                   overrun_q, overrun_d;
  logic [NUM_ENEMIES-1:0] kill_q, kill_d;
  logic                   hit_pulse_q, hit_pulse_d;
  logic                   respawn_q, respawn_d;
  logic                   invuln_q, busy_q, game_over_q;

  logic [7:0] slot_pos;
  logic       slot_alive;
  logic [3:0] kill_cnt;
  logic [8:0] score_sum;

  // Current scan slot and number of kills gathered this frame
  always_comb begin
    slot_pos   = '0;
    slot_alive = 1'b0;
    kill_cnt   = '0;
    for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
      if (IDX_W'(i) == idx_q) begin
        slot_pos   = enemy_pos[8*i +: 8];
        slot_alive = enemy_alive[i];
      end
      kill_cnt = kill_cnt + 4'(kill_acc_q[i]);
    end
    score_sum = {1'b0, score_q} + 9'(kill_cnt);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    kill_acc_d  = kill_acc_q;
    hit_d       = hit_q;
    lives_d     = lives_q;
    score_d     = score_q;
    inv_d       = inv_q;
    overrun_d   = overrun_q;
    kill_d      = '0;
    hit_pulse_d = 1'b0;
    respawn_d   = 1'b0;

    // Frame tick always ages invulnerability unless the game has ended
    if (frame_trigger && (state_q != GAME_OVER) && (inv_q != '0)) begin
      inv_d = inv_q - INV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (frame_trigger) begin
          state_d    = SCAN;
          idx_d      = '0;
          kill_acc_d = '0;
          hit_d      = 1'b0;
        end
      end
      SCAN: begin
        if (frame_trigger) overrun_d = 1'b1;
        // Sword contact takes priority over player contact on the same slot
        if (slot_alive && (sword_visible != 4'd0) && (sword_pos == slot_pos)) begin
          for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
            if (IDX_W'(i) == idx_q) kill_acc_d[i] = 1'b1;
          end
        end else if (slot_alive && (slot_pos == player_pos) && (inv_q == '0)) begin
          hit_d = 1'b1;
        end
        if (idx_q == LAST_IDX) state_d = RESOLVE;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      RESOLVE: begin
        if (frame_trigger) overrun_d = 1'b1;
        kill_d  = kill_acc_q;
        score_d = (score_sum > 9'd255) ? 8'hFF : score_sum[7:0];
        state_d = IDLE;
        if (hit_q) begin
          hit_pulse_d = 1'b1;
          lives_d     = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          if (lives_d == 3'd0) begin
            state_d = GAME_OVER;
          end else begin
            respawn_d = 1'b1;
            inv_d     = INV_W'(INVULN_FRAMES);
          end
        end
      end
      GAME_OVER: begin
        if (restart) begin
          lives_d   = 3'(LIVES_INIT);
          score_d   = '0;
          inv_d     = '0;
          overrun_d = 1'b0;
          respawn_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      kill_acc_q  <= '0;
      hit_q       <= 1'b0;
      lives_q     <= 3'(LIVES_INIT);
      score_q     <= '0;
      inv_q       <= '0;
      overrun_q   <= 1'b0;
      kill_q      <= '0;
      hit_pulse_q <= 1'b0;
      respawn_q   <= 1'b0;
      invuln_q    <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      kill_acc_q  <= kill_acc_d;
      hit_q       <= hit_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      inv_q       <= inv_d;
      overrun_q   <= overrun_d;
      kill_q      <= kill_d;
      hit_pulse_q <= hit_pulse_d;
      respawn_q   <= respawn_d;
      invuln_q    <= (inv_d != '0);
      busy_q      <= (state_d == SCAN) || (state_d == RESOLVE);
      game_over_q <= (state_d == GAME_OVER);
    end
  end

  assign enemy_kill    = kill_q;
  assign player_hit    = hit_pulse_q;
  assign respawn_req   = respawn_q;
  assign respawn_pos   = RESPAWN_POS;
  assign lives         = lives_q;
  assign score         = score_q;
  assign invulnerable  = invuln_q;
  assign game_over     = game_over_q;
  assign busy          = busy_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller: directed scenarios plus random frames
// checked against a frame-level model of lives, score and invulnerability.
module tb_game_state_controller;

  localparam int N      = 4;
  localparam int LIVES0 = 3;
  localparam int INVF   = 30;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_trigger;
  logic           restart;
  logic [7:0]     player_pos;
  logic [7:0]     sword_pos;
  logic [3:0]     sword_visible;
  logic [8*N-1:0] enemy_pos;
  logic [N-1:0]   enemy_alive;
  logic [N-1:0]   enemy_kill;
  logic           player_hit;
  logic           respawn_req;
  logic [7:0]     respawn_pos;
  logic [2:0]     lives;
  logic [7:0]     score;
  logic           invulnerable;
  logic           game_over;
  logic           busy;
  logic           frame_overrun;

  game_state_controller #(
    .NUM_ENEMIES(N), .LIVES_INIT(LIVES0), .INVULN_FRAMES(INVF), .RESPAWN_POS(8'h13)
  ) dut (
    .clk(clk), .reset(reset), .frame_trigger(frame_trigger), .restart(restart),
    .player_pos(player_pos), .sword_pos(sword_pos), .sword_visible(sword_visible),
    .enemy_pos(enemy_pos), .enemy_alive(enemy_alive), .enemy_kill(enemy_kill),
    .player_hit(player_hit), .respawn_req(respawn_req), .respawn_pos(respawn_pos),
    .lives(lives), .score(score), .invulnerable(invulnerable), .game_over(game_over),
    .busy(busy), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model state
  int m_lives, m_score, m_inv;
  bit m_go, m_ovr, m_last_hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_lives = LIVES0; m_score = 0; m_inv = 0; m_go = 0; m_ovr = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_lives"}, 32'(lives), 32'(m_lives));
    chk({tag, "_score"}, 32'(score), 32'(m_score));
    chk({tag, "_invuln"}, 32'(invulnerable), 32'(m_inv != 0));
    chk({tag, "_gameover"}, 32'(game_over), 32'(m_go));
    chk({tag, "_overrun"}, 32'(frame_overrun), 32'(m_ovr));
  endtask

  function automatic logic [7:0] slot(input logic [8*N-1:0] ep, input int i);
    return ep[8*i +: 8];
  endfunction

  // Applies one frame; pulses are checked in the exact cycle N+1 after the trigger edge
  task automatic do_frame(input logic [7:0] pp, input logic [7:0] sp, input logic [3:0] sv,
                          input logic [8*N-1:0] ep, input logic [N-1:0] al);
    logic [N-1:0] kmask;
    bit hit, resp;
    int nk;
    player_pos = pp; sword_pos = sp; sword_visible = sv; enemy_pos = ep; enemy_alive = al;
    frame_trigger = 1'b1;
    tick();
    frame_trigger = 1'b0;
    m_last_hit = 0;
    if (m_go) begin
      for (int k = 0; k <= N + 1; k++) begin
        chk("go_busy", 32'(busy), 0);
        chk("go_pulses", 32'({enemy_kill, player_hit, respawn_req}), 0);
        tick();
      end
      chk_state("go_frame");
      return;
    end
    if (m_inv > 0) m_inv--;
    kmask = '0; hit = 0; nk = 0;
    for (int i = 0; i < N; i++) begin
      if (al[i] && sv != 0 && sp == slot(ep, i)) begin
        kmask[i] = 1'b1; nk++;
      end else if (al[i] && slot(ep, i) == pp && m_inv == 0) begin
        hit = 1;
      end
    end
    m_score = (m_score + nk > 255) ? 255 : m_score + nk;
    resp = 0;
    if (hit) begin
      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      if (m_lives == 0) m_go = 1;
      else begin resp = 1; m_inv = INVF; end
    end
    m_last_hit = hit;
    for (int k = 0; k <= N; k++) begin
      chk("scan_busy", 32'(busy), 1);
      chk("scan_pulses", 32'({enemy_kill, player_hit, respawn_req}), 0);
      tick();
    end
    chk("enemy_kill", 32'(enemy_kill), 32'(kmask));
    chk("player_hit", 32'(player_hit), 32'(hit));
    chk("respawn_req", 32'(respawn_req), 32'(resp));
    chk("busy_done", 32'(busy), 0);
    chk_state("frame");
    tick();
    chk("pulse_width", 32'({enemy_kill, player_hit, respawn_req}), 0);
  endtask

  task automatic do_restart();
    bit exp_resp;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    exp_resp = m_go;
    if (m_go) model_reset();
    chk("restart_resp", 32'(respawn_req), 32'(exp_resp));
    chk("restart_busy", 32'(busy), 0);
    chk_state("restart");
    tick();
    chk("restart_resp_width", 32'(respawn_req), 0);
  endtask

  task automatic quiet_frames(input int n);
    for (int f = 0; f < n; f++) do_frame(8'h13, 8'h00, 4'd0, '0, '0);
  endtask

  initial begin
    logic [7:0] pool [4];
    logic [8*N-1:0] ep;
    pool[0] = 8'h13; pool[1] = 8'h23; pool[2] = 8'h45; pool[3] = 8'h50;
    reset = 1'b1; frame_trigger = 1'b0; restart = 1'b0;
    player_pos = '0; sword_pos = '0; sword_visible = '0; enemy_pos = '0; enemy_alive = '0;
    model_reset();
    #12;
    chk("reset_pulses", 32'({enemy_kill, player_hit, respawn_req}), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("respawn_pos", 32'(respawn_pos), 32'h13);
    chk_state("reset");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Sword kill on slot 1
    ep = {8'h00, 8'h00, 8'h23, 8'h00};
    do_frame(8'h13, 8'h23, 4'd1, ep, 4'b0010);

    // Player hit, invulnerability, then eventual re-hit
    ep = {8'h00, 8'h00, 8'h00, 8'h45};
    do_frame(8'h45, 8'h00, 4'd0, ep, 4'b0001);
    chk("first_hit", 32'(m_last_hit), 1);
    do_frame(8'h45, 8'h00, 4'd0, ep, 4'b0001);
    chk("invuln_protects", 32'(m_last_hit), 0);
    for (int f = 0; f < 40 && !m_last_hit; f++) do_frame(8'h45, 8'h00, 4'd0, ep, 4'b0001);
    chk("rehit_lives", 32'(lives), 1);
    quiet_frames(INVF);

    // Sword priority over player contact on the same slot
    ep = {8'h00, 8'h50, 8'h00, 8'h00};
    do_frame(8'h50, 8'h50, 4'd8, ep, 4'b0100);
    do_restart();

    // Last life lost, ignored triggers, then restart
    ep = {8'h00, 8'h00, 8'h00, 8'h45};
    do_frame(8'h45, 8'h00, 4'd0, ep, 4'b0001);
    chk("game_over_now", 32'(game_over), 1);
    do_frame(8'h45, 8'h45, 4'd1, ep, 4'b0001);
    do_frame(8'h13, 8'h45, 4'd1, ep, 4'b0001);
    do_restart();

    // Overrun: second trigger while busy starts no new scan
    ep = {8'h00, 8'h00, 8'h00, 8'h23};
    player_pos = 8'h13; sword_pos = 8'h23; sword_visible = 4'd2;
    enemy_pos = ep; enemy_alive = 4'b0001;
    frame_trigger = 1'b1; tick(); frame_trigger = 1'b0;
    tick();
    frame_trigger = 1'b1; tick(); frame_trigger = 1'b0;
    m_ovr = 1; m_score++;
    for (int k = 2; k <= N; k++) tick();
    chk("ovr_kill", 32'(enemy_kill), 32'h1);
    chk_state("ovr");
    for (int k = 0; k < N + 3; k++) begin
      tick();
      chk("ovr_single_scan", 32'({busy, enemy_kill}), 0);
    end

    // Score saturation
    ep = {8'h77, 8'h77, 8'h77, 8'h77};
    while (m_score <= 250) do_frame(8'h13, 8'h77, 4'd1, ep, 4'b1111);
    do_frame(8'h13, 8'h77, 4'd1, ep, 4'(4'b1111 >> (4 - (254 - m_score))));
    chk("score_254", 32'(score), 254);
    do_frame(8'h13, 8'h77, 4'd1, ep, 4'b1111);
    chk("score_sat", 32'(score), 255);

    // Random frames
    for (int f = 0; f < 150; f++) begin
      for (int i = 0; i < N; i++) ep[8*i +: 8] = pool[$urandom_range(0, 3)];
      do_frame(pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
               4'($urandom_range(0, 3)), ep, 4'($urandom));
      if (m_go && ($urandom_range(0, 2) == 0)) do_restart();
      repeat ($urandom_range(0, 2)) tick();
    end

    // Asynchronous reset mid-scan aborts the frame
    ep = {8'h00, 8'h00, 8'h00, 8'h23};
    player_pos = 8'h13; sword_pos = 8'h23; sword_visible = 4'd1;
    enemy_pos = ep; enemy_alive = 4'b0001;
    if (m_go) do_restart();
    frame_trigger = 1'b1; tick(); frame_trigger = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("areset_pulses", 32'({enemy_kill, player_hit, respawn_req}), 0);
    chk("areset_busy", 32'(busy), 0);
    chk_state("areset");
    tick();
    reset = 1'b0;
    for (int k = 0; k < N + 3; k++) begin
      tick();
      chk("areset_no_kill", 32'({busy, enemy_kill}), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
